// File: rtl/parallel_send.sv
// Test-pattern transmitter for the 32-bit parallel link: frames of identical
// words carrying the frame sequence number, with flow control and error injection.
module parallel_send #(
    parameter int FRAME_LEN  = 1024,
    parameter int GAP_CYC    = 4,
    parameter int NUM_FRAMES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLR,
    input  logic        START,
    input  logic        STOP,
    input  logic        DORDY,
    input  logic        ERR_INJ,
    output logic        DOPUSH,
    output logic [31:0] DOUT,
    output logic        BUSY,
    output logic [15:0] FRAME_CNT,
    output logic [7:0]  INJ_CNT
);

    localparam logic [15:0] LAST_WORD   = 16'(FRAME_LEN - 1);
    localparam logic [15:0] LAST_GAP    = 16'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [32:0] FRAME_LIMIT = 33'(NUM_FRAMES);
    localparam bit          HAS_GAP     = (GAP_CYC != 0);
    localparam bit          HAS_LIMIT   = (NUM_FRAMES != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] seq;
    logic [31:0] frm_cnt;
    logic [15:0] word_cnt;
    logic [15:0] gap_cnt;
    logic        stop_pend;
    logic        inj_pend;

    logic        issue;
    logic        frame_end;
    logic        gap_end;
    logic        limit_hit;
    logic        stop_now;
    logic        inj;

    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        frame_end = 1'b0;
        gap_end   = 1'b0;
        inj       = ERR_INJ | inj_pend;
        stop_now  = stop_pend | STOP;
        // frm_cnt+1 is widened so a full 32-bit count cannot alias the limit
        limit_hit = HAS_LIMIT && (({1'b0, frm_cnt} + 33'd1) == FRAME_LIMIT);
        unique case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (DORDY) begin
                    issue = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        frame_end = 1'b1;
                        if (stop_now || limit_hit) begin
                            state_nxt = S_IDLE;
                        end else if (HAS_GAP) begin
                            state_nxt = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    gap_end   = 1'b1;
                    state_nxt = stop_now ? S_IDLE : S_SEND;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            DOPUSH    <= 1'b0;
            DOUT      <= '0;
            FRAME_CNT <= '0;
            INJ_CNT   <= '0;
            seq       <= '0;
            frm_cnt   <= '0;
            word_cnt  <= '0;
            gap_cnt   <= '0;
            stop_pend <= 1'b0;
            inj_pend  <= 1'b0;
        end else begin
            DOPUSH <= issue;

            if (issue) begin
                DOUT     <= seq ^ {31'd0, inj};
                inj_pend <= 1'b0;
                word_cnt <= frame_end ? 16'd0 : word_cnt + 16'd1;
                if (inj && (INJ_CNT != 8'hFF)) begin
                    INJ_CNT <= INJ_CNT + 8'd1;
                end
            end else if (ERR_INJ) begin
                inj_pend <= 1'b1;
            end

            if (frame_end) begin
                seq       <= seq + 32'd1;
                FRAME_CNT <= FRAME_CNT + 16'd1;
                frm_cnt   <= frm_cnt + 32'd1;
            end

            if (state == S_GAP) begin
                gap_cnt <= gap_end ? 16'd0 : gap_cnt + 16'd1;
            end

            if (state == S_IDLE) begin
                stop_pend <= 1'b0;
                if (START) begin
                    frm_cnt <= '0;
                end
            end else if (STOP) begin
                stop_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_parallel_send.sv
// Bench for parallel_send: two instances (gapped/free-running and
// back-to-back/3-frame) share stimulus and are checked against a word-level model.
module tb_parallel_send;

    localparam int FL = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CLR = 1'b0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        DORDY = 1'b1;
    logic        ERR_INJ = 1'b0;

    logic [1:0]  push;
    logic [1:0]  busy;
    logic [31:0] dout [2];
    logic [15:0] fcnt [2];
    logic [7:0]  icnt [2];

    int n_chk = 0;
    int n_err = 0;

    int          words [2];
    bit          pend  [2];
    int          inj_n [2];
    logic [31:0] last  [2];
    bit          pbusy [2];

    always #5 CLK = ~CLK;

    parallel_send #(
        .FRAME_LEN(FL), .GAP_CYC(2), .NUM_FRAMES(0)
    ) u_gap (
        .CLK(CLK), .RST(RST), .CLR(CLR), .START(START), .STOP(STOP),
        .DORDY(DORDY), .ERR_INJ(ERR_INJ), .DOPUSH(push[0]), .DOUT(dout[0]),
        .BUSY(busy[0]), .FRAME_CNT(fcnt[0]), .INJ_CNT(icnt[0])
    );

    parallel_send #(
        .FRAME_LEN(FL), .GAP_CYC(0), .NUM_FRAMES(3)
    ) u_b2b (
        .CLK(CLK), .RST(RST), .CLR(CLR), .START(START), .STOP(STOP),
        .DORDY(DORDY), .ERR_INJ(ERR_INJ), .DOPUSH(push[1]), .DOUT(dout[1]),
        .BUSY(busy[1]), .FRAME_CNT(fcnt[1]), .INJ_CNT(icnt[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word-level model: the n-th word since reset belongs to frame n/FL and
    // carries that frame number; the first word issued after an injection
    // request has bit0 flipped.
    task automatic observe(input int i, input bit rst_e, input bit inj_e);
        logic [31:0] exp;
        int          sat;
        if (rst_e) begin
            words[i] = 0;
            pend[i]  = 1'b0;
            inj_n[i] = 0;
            last[i]  = '0;
        end else begin
            if (inj_e) pend[i] = 1'b1;
            if (push[i]) begin
                exp = 32'(words[i] / FL) ^ {31'd0, pend[i]};
                check($sformatf("dout%0d", i), dout[i], exp);
                if (pend[i]) inj_n[i]++;
                pend[i] = 1'b0;
                words[i]++;
                last[i] = exp;
            end else begin
                check($sformatf("hold%0d", i), dout[i], last[i]);
            end
            if (pbusy[i] && !busy[i]) begin
                check($sformatf("whole_frames%0d", i), 32'(words[i] % FL), 32'd0);
            end
        end
        pbusy[i] = busy[i];
        sat = (inj_n[i] > 255) ? 255 : inj_n[i];
        check($sformatf("frame_cnt%0d", i), 32'(fcnt[i]),
              32'((words[i] / FL) % 65536));
        check($sformatf("inj_cnt%0d", i), 32'(icnt[i]), 32'(sat));
    endtask

    task automatic tick();
        bit rst_e;
        bit inj_e;
        rst_e = RST | CLR;
        inj_e = ERR_INJ;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) observe(i, rst_e, inj_e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        START = 1'b0;
        STOP  = 1'b1;
        DORDY = 1'b1;
        while (busy != 2'b00 && n < 200) begin
            tick();
            n++;
        end
        STOP = 1'b0;
        if (busy != 2'b00) check("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] pat0;
        logic [15:0] pat1;
        logic [12:0] pat3;
        pat0 = 16'b1111_0011_1100_1111;
        pat1 = 16'h0FFF;
        pat3 = 13'h0F39;

        // reset state
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_push", 32'(push), 32'd0);
        check("rst_dout", dout[0], 32'd0);

        // framing, gap of 2 vs back-to-back with a 3-frame limit
        START = 1'b1;
        tick();
        START = 1'b0;
        check("start_busy", 32'(busy), 32'd3);
        check("start_push", 32'(push), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("pat_gap_%0d", k), 32'(push[0]), 32'(pat0[k-1]));
            check($sformatf("pat_b2b_%0d", k), 32'(push[1]), 32'(pat1[k-1]));
            check($sformatf("busy_b2b_%0d", k), 32'(busy[1]), 32'(k < 12));
            if (k == 4) check("fcnt_after_4", 32'(fcnt[0]), 32'd1);
        end

        // STOP during the gap: no further frame
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        tick();
        check("stop_in_gap_busy", 32'(busy[0]), 32'd0);
        repeat (3) tick();
        check("stop_in_gap_fcnt", 32'(fcnt[0]), 32'd3);
        check("stop_in_gap_push", 32'(push[0]), 32'd0);

        // DORDY stalls, then STOP on word 2 of 4
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            DORDY = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            STOP  = (k == 11);
            tick();
            check($sformatf("stall_push_%0d", k), 32'(push[0]), 32'(pat3[k-1]));
            check($sformatf("stall_busy_%0d", k), 32'(busy[0]), 32'(k < 12));
        end
        STOP = 1'b0;
        DORDY = 1'b1;
        repeat (4) tick();
        wait_idle();
        check("seq5_ready", 32'(fcnt[0]), 32'd5);

        // injection while stalled, in frame 5
        DORDY = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        ERR_INJ = 1'b1;
        tick();
        ERR_INJ = 1'b0;
        tick();
        DORDY = 1'b1;
        tick();
        check("inj_push", 32'(push[0]), 32'd1);
        check("inj_word", dout[0], 32'h4);
        check("inj_cnt1", 32'(icnt[0]), 32'd1);
        tick();
        check("post_inj_word", dout[0], 32'h5);
        wait_idle();

        // saturation of the injection counter
        START = 1'b1;
        tick();
        START = 1'b0;
        ERR_INJ = 1'b1;
        repeat (420) tick();
        ERR_INJ = 1'b0;
        check("inj_sat", 32'(icnt[0]), 32'hFF);
        wait_idle();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            DORDY   = ($urandom_range(0, 3) != 0);
            ERR_INJ = ($urandom_range(0, 15) == 0);
            START   = ($urandom_range(0, 19) == 0);
            STOP    = ($urandom_range(0, 59) == 0);
            CLR     = ($urandom_range(0, 399) == 0);
            tick();
        end
        ERR_INJ = 1'b0;
        CLR = 1'b0;
        wait_idle();

        // reset held mid-frame, then restart from seq 0
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (3) tick();
        check("mid_frame_busy", 32'(busy[0]), 32'd1);
        RST = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_push", 32'(push), 32'd0);
        check("rst2_dout", dout[0], 32'd0);
        check("rst2_fcnt", 32'(fcnt[0]), 32'd0);
        check("rst2_icnt", 32'(icnt[0]), 32'd0);
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        check("restart_push", 32'(push[0]), 32'd1);
        check("restart_word", dout[0], 32'd0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
